// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and strobe/busy issue sequencer feeding a TX-only UART
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_n_i,
    input  logic              wr_i,
    input  logic [7:0]        dat_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic              idle_o,
    output logic              uart_wr_o,
    output logic [7:0]        uart_dat_o,
    input  logic              uart_busy_i
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    logic [7:0]      mem_q [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    state_t          state_q;
    logic            uart_wr_q;
    logic [7:0]      uart_dat_q;
    logic            push;
    logic            pop;

    // Occupancy comes straight from the extra pointer bit, so full and empty
    // are never ambiguous and both reflect start-of-cycle state.
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = (level_o == (ADDR_W + 1)'(DEPTH));
    assign empty_o    = (level_o == '0);
    assign overflow_o = overflow_q;
    assign idle_o     = empty_o && (state_q == ST_IDLE);
    assign uart_wr_o  = uart_wr_q;
    assign uart_dat_o = uart_dat_q;

    // Push is refused while full even if a pop frees a slot this cycle.
    always_comb begin
        push       = wr_i && !full_o;
        pop        = (state_q == ST_IDLE) && !empty_o;
        wr_ptr_d   = wr_ptr_q + (ADDR_W + 1)'(push);
        rd_ptr_d   = rd_ptr_q + (ADDR_W + 1)'(pop);
        overflow_d = overflow_q || (wr_i && full_o);
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_n_i && push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= dat_i;
        end
    end

    // Pointers and sticky overflow flag.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Issue sequencer: pop in IDLE, strobe for one cycle, then wait for the
    // UART busy pulse to rise and fall before popping again.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q    <= ST_IDLE;
            uart_wr_q  <= 1'b0;
            uart_dat_q <= 8'h00;
        end else begin
            uart_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        uart_dat_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                        uart_wr_q  <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (uart_busy_i) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!uart_busy_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DIV   = 104;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr;
    logic [7:0]    dat;
    logic          busy;
    logic          full, empty, ovf, idle, uwr;
    logic [AW:0]   level;
    logic [7:0]    udat;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    logic [7:0] mq[$];
    logic [7:0] rx[$];
    logic [7:0] m_dat;
    bit m_ovf, m_can_pop, m_issue, m_rise, m_fall, started;
    bit o_issue, o_rise, o_fall, do_pop;
    int sz;

    // UART stand-in state
    bit stall, real_mode, prev_wr, line;
    int bcnt;
    logic [9:0] frame;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rstn),
        .wr_i        (wr),
        .dat_i       (dat),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .overflow_o  (ovf),
        .idle_o      (idle),
        .uart_wr_o   (uwr),
        .uart_dat_o  (udat),
        .uart_busy_i (busy)
    );

    always #41.667 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a queue of stored bytes plus a handoff token
    // that is returned once the UART has been seen busy and then free again.
    always @(posedge clk) begin
        if (!rstn) begin
            mq.delete();
            m_ovf = 0; m_can_pop = 1; m_issue = 0; m_rise = 0; m_fall = 0;
            m_dat = 8'h00; started = 1;
        end else begin
            sz = mq.size();
            o_issue = m_issue; o_rise = m_rise; o_fall = m_fall;
            do_pop = m_can_pop && sz > 0;
            m_issue = do_pop;
            if (do_pop) begin
                m_dat = mq.pop_front();
                m_can_pop = 0;
            end
            if (o_issue) m_rise = 1;
            if (o_rise && busy) begin m_rise = 0; m_fall = 1; end
            if (o_fall && !busy) begin m_fall = 0; m_can_pop = 1; end
            if (wr) begin
                if (sz < DEPTH) mq.push_back(dat);
                else m_ovf = 1;
            end
        end
    end

    // Per-cycle comparison against the model, then the UART stand-in.
    always @(negedge clk) begin
        if (started) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("idle", 32'(idle), 32'(mq.size() == 0 && m_can_pop));
            chk("uart_wr", 32'(uwr), 32'(m_issue));
            chk("uart_dat", 32'(udat), 32'(m_dat));
            if (uwr) begin
                chk("strobe_while_busy", 32'(busy), 32'd0);
                chk("strobe_back_to_back", 32'(prev_wr), 32'd0);
                rx.push_back(udat);
                frame = {1'b1, udat, 1'b0};
            end
        end
        if (prev_wr) begin
            busy = 1'b1;
            bcnt = real_mode ? 10 * DIV : int'($urandom_range(1, 6));
        end else if (busy && !stall) begin
            bcnt--;
            if (bcnt == 0) busy = 1'b0;
        end
        line = (busy && real_mode) ? frame[(10 * DIV - bcnt) / DIV] : 1'b1;
        prev_wr = uwr;
    end

    task automatic push_byte(input logic [7:0] b);
        wr = 1'b1; dat = b;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(idle && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, 32'(rx.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rx.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(rx[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [7:0] exp[$];
        logic [9:0] a5_line;
        int n;
        rstn = 1'b0; wr = 1'b0; dat = 8'h00; busy = 1'b0; line = 1'b1;
        stall = 0; real_mode = 0; prev_wr = 0; bcnt = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_dat", 32'(udat), 32'h00);

        // T1: three back-to-back bytes
        rx.delete();
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        wait_idle("t1", 200);
        exp = '{8'h41, 8'h42, 8'h43};
        check_rx("t1", exp);
        chk("t1_idle", 32'(idle), 32'd1);

        // T2: UART stalled, fill to full and overflow by one
        rx.delete(); exp.delete();
        stall = 1;
        push_byte(8'hEE); exp.push_back(8'hEE);
        for (int i = 0; i < DEPTH; i++) begin
            dat = 8'($urandom);
            exp.push_back(dat);
            push_byte(dat);
        end
        push_byte(8'hFF);
        repeat (3) @(negedge clk);
        chk("t2_level", 32'(level), 32'd16);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_overflow", 32'(ovf), 32'd1);
        stall = 0;
        wait_idle("t2", 400);
        check_rx("t2", exp);

        // T3: 40 bytes through the 16-deep FIFO with random gaps
        do_reset();
        chk("t3_ovf_cleared", 32'(ovf), 32'd0);
        rx.delete(); exp.delete();
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (full && n < 500) begin @(negedge clk); n++; end
            push_byte(8'(i));
            exp.push_back(8'(i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("t3", 800);
        check_rx("t3", exp);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_level", 32'(level), 32'd0);

        // T4: push on the same edge as a pop with five bytes stored
        do_reset();
        rx.delete();
        stall = 1;
        push_byte(8'hC0);
        for (int i = 1; i <= 5; i++) push_byte(8'(8'hC0 + i));
        stall = 0;
        n = 0;
        while (!m_can_pop && n < 50) begin @(negedge clk); n++; end
        chk("t4_wait", 32'(n < 50), 32'd1);
        chk("t4_level_before", 32'(level), 32'd5);
        push_byte(8'hC6);
        chk("t4_level_after", 32'(level), 32'd5);
        wait_idle("t4", 200);
        exp = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        check_rx("t4", exp);

        // T5: reset while waiting for busy to fall with four bytes queued
        rx.delete();
        stall = 1;
        push_byte(8'hD0);
        for (int i = 1; i <= 4; i++) push_byte(8'(8'hD0 + i));
        repeat (4) @(negedge clk);
        chk("t5_level_pre", 32'(level), 32'd4);
        do_reset();
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_full", 32'(full), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        chk("t5_wr", 32'(uwr), 32'd0);
        chk("t5_dat", 32'(udat), 32'h00);
        chk("t5_ovf", 32'(ovf), 32'd0);
        stall = 0;
        repeat (15) @(negedge clk);
        exp = '{8'hD0};
        check_rx("t5_flushed", exp);
        push_byte(8'h55);
        wait_idle("t5", 200);
        exp = '{8'hD0, 8'h55};
        check_rx("t5", exp);

        // T6: 0xA5 framed on a bit-timed line
        real_mode = 1;
        rx.delete();
        push_byte(8'hA5);
        n = 0;
        while (line && n < 20) begin @(negedge clk); n++; end
        chk("t6_start_seen", 32'(n < 20), 32'd1);
        a5_line = 10'b1101001010;
        repeat (DIV / 2) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("t6_bit%0d", b), 32'(line), 32'(a5_line[b]));
            repeat (DIV) @(negedge clk);
        end
        wait_idle("t6", 12 * DIV);
        exp = '{8'hA5};
        check_rx("t6", exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
